tcbm_drive_responder: RTL and testbench
=======================================

// Module: tcbm_drive_responder
// PURPOSE
//  Drive-side end of the TCBM (1551) byte link. It answers the host's DAV strobe with ACK and
//  receives command bytes (0x81) and data bytes (0x82) into a byte stream. For reads (0x83) it
//  returns one byte from a source stream, along with 2-bit STATUS.
//  It sits behind the paddle's port A (data), port B[1:0] (STATUS) and port C[7:6] (DAV/ACK) pins.
// PARAMETERS
//  SYNC_STAGES   2       flops on the asynchronous dav input (>=2)
//  TIMEOUT       65535   clocks allowed waiting for any host edge before abort (>=16)
// PORTS
//  clock          in   1  system clock
//  _reset         in   1  asynchronous, active-low reset
//  dav            in   1  host DAV strobe, active low, asynchronous to clock
//  ack            out  1  drive ACK strobe, active low
//  bus_in         in   8  TCBM data lines as sampled from the pins
//  bus_out        out  8  data driven toward the host during a read
//  bus_oe         out  1  1 = drive bus_out onto the TCBM data lines
//  status         out  2  STATUS lines to the host (00 ok, 01 timeout, 10 bad code, 11 EOI)
//  rx_data        out  8  received byte
//  rx_is_cmd      out  1  1 = rx_data came from a 0x81 phase; 0 = from a 0x82 phase
//  rx_valid       out  1  rx_data valid; held until it is accepted
//  rx_ready       in   1  sink accepts rx_data when rx_valid && rx_ready
//  rx_status      in   2  status the sink reports for the accepted byte
//  tx_data        in   8  byte to return on a read
//  tx_status      in   2  status to return with tx_data (11 = EOI)
//  tx_valid       in   1  source has a byte ready
//  tx_ready       out  1  one-cycle pulse: tx_data/tx_status are consumed
//  err            out  1  one-cycle pulse on timeout abort or bad code
// BEHAVIOUR
//  Reset: ack=1, bus_oe=0, bus_out=00, status=00, rx_valid=0, rx_is_cmd=0, tx_ready=0,
//   err=0, state=IDLE, and every synchroniser flop=1. Reset mid-transfer aborts with no partial output.
//  Input sync: dav_s = dav after SYNC_STAGES flops. All decisions use dav_s levels only.
//  Transfer: the host asserts dav low, the drive asserts ack low, the host releases dav high,
//   the drive releases ack high. Every byte goes through this 4-phase cycle.
//  FSM:
//   IDLE: on dav_s=0, latch code=bus_in -> CODE_ACK.
//   CODE_ACK: ack=0; if code is 0x81/0x82/0x83, status=00; otherwise status=10 and err pulses.
//     On dav_s=1 -> CODE_REL.
//   CODE_REL: ack=1; if code is 0x81/0x82 -> WR_WAIT, if 0x83 -> RD_WAIT, otherwise -> IDLE.
//   WR_WAIT: on dav_s=0, rx_data=bus_in, rx_is_cmd=(code==0x81), rx_valid=1 -> WR_HOLD.
//   WR_HOLD: when rx_ready=1, rx_valid=0 and status=rx_status -> WR_ACK
//     (ack falls on the next clock).
//   WR_ACK: ack=0; on dav_s=1 -> WR_REL.
//   WR_REL: ack=1 -> IDLE.
//   RD_WAIT: on dav_s=0 -> RD_FETCH.
//   RD_FETCH: when tx_valid=1, bus_out=tx_data, status=tx_status, bus_oe=1, tx_ready pulses
//     -> RD_ACK. ack stays 1 that cycle, giving data one clock of setup before the strobe.
//   RD_ACK: ack=0; on dav_s=1, bus_oe=0 -> RD_REL.
//   RD_REL: ack=1 -> IDLE.
//  Latency: pin dav falls to ack low = SYNC_STAGES+1 clocks (code phase), plus any rx_ready /
//   tx_valid wait. Pin dav rises to ack high = SYNC_STAGES+2 clocks.
//  Timeout: a counter clears on every state change and counts in all states except IDLE,
//   WR_HOLD and RD_FETCH. At TIMEOUT it forces ack=1, bus_oe=0, rx_valid=0, status=01,
//   pulses err and returns to IDLE. status stays 01 until the next code phase.
//  Only one byte follows each code. status holds its value between transfers.
//  dav already low when reset releases: treated as a new code phase once dav_s=0.
//  tx_valid and rx_ready are ignored outside RD_FETCH and WR_HOLD.
// TESTING
//  T1 write command: code 0x81, then byte 0x49 with rx_ready=1 and rx_status=00.
//   -> rx_data=49, rx_is_cmd=1, one rx accept, two full ack cycles, status=00.
//  T2 read with EOI: code 0x83, tx_valid=1, tx_data=A5, tx_status=11.
//   -> bus_oe=1 with bus_out=A5 one clock before ack=0, status=11; bus_oe=0 after dav rises.
//  T3 backpressure: code 0x82 and byte 0x10 with rx_ready held low for 50 clocks.
//   -> ack stays 1 and rx_valid stays 1 throughout; ack falls 1 clock after rx_ready=1.
//  T4 bad code 0x55 -> one ack cycle, status=10, err pulse once, FSM back in IDLE, no rx_valid.
//  T5 timeout with TIMEOUT=16: code 0x82, and the host never drops dav again.
//   -> after 16 clocks in WR_WAIT: err pulse, status=01, ack=1, bus_oe=0.
//  T6 _reset low in RD_ACK -> ack=1, bus_oe=0 immediately (async);
//   after release, a clean 0x83 transfer works.

Source files
------------

// File: rtl/tcbm_drive_responder.sv
// tcbm_drive_responder
// Drive-side end of the 1551 TCBM byte link. Every byte uses a 4-phase DAV/ACK
// handshake. A code byte comes first. 0x81 and 0x82 are followed by one byte
// that goes to the rx stream. 0x83 is followed by one byte returned from the
// tx stream, with STATUS. A watchdog aborts any transfer that stalls on the host.
module tcbm_drive_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       dav_i,
    output logic       ack_o,
    input  logic [7:0] bus_in_i,
    output logic [7:0] bus_out_o,
    output logic       bus_oe_o,
    output logic [1:0] status_o,
    output logic [7:0] rx_data_o,
    output logic       rx_is_cmd_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [1:0] rx_status_i,
    input  logic [7:0] tx_data_i,
    input  logic [1:0] tx_status_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       err_o
);

    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0] CODE_CMD  = 8'h81;
    localparam logic [7:0] CODE_DATA = 8'h82;
    localparam logic [7:0] CODE_READ = 8'h83;
    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_TMO    = 2'b01;
    localparam logic [1:0] ST_BAD    = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CODE_ACK = 4'd1,
        S_CODE_REL = 4'd2,
        S_WR_WAIT  = 4'd3,
        S_WR_HOLD  = 4'd4,
        S_WR_ACK   = 4'd5,
        S_WR_REL   = 4'd6,
        S_RD_WAIT  = 4'd7,
        S_RD_FETCH = 4'd8,
        S_RD_ACK   = 4'd9,
        S_RD_REL   = 4'd10
    } state_e;

    // A code byte is valid only if it is one of the three link commands.
    function automatic logic valid_code(input logic [7:0] c);
        return (c == CODE_CMD) || (c == CODE_DATA) || (c == CODE_READ);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dav_s;
    state_e                 state_q;
    state_e                 nxt_s;
    logic [7:0]             code_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   timed_s;
    logic                   abort_s;
    logic                   ack_q;
    logic                   bus_oe_q;
    logic [7:0]             bus_out_q;
    logic [1:0]             status_q;
    logic [7:0]             rx_data_q;
    logic                   rx_is_cmd_q;
    logic                   rx_valid_q;
    logic                   tx_ready_q;
    logic                   err_q;

    assign dav_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous DAV pin. It idles high (released).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dav_i};
        end
    end

    // Natural next state from the handshake and the stream handshakes, ignoring the watchdog.
    always_comb begin
        nxt_s = state_q;
        case (state_q)
            S_IDLE:     if (!dav_s) nxt_s = S_CODE_ACK; else nxt_s = state_q;
            S_CODE_ACK: if (dav_s)  nxt_s = S_CODE_REL; else nxt_s = state_q;
            S_CODE_REL: begin
                if ((code_q == CODE_CMD) || (code_q == CODE_DATA)) begin
                    nxt_s = S_WR_WAIT;
                end else if (code_q == CODE_READ) begin
                    nxt_s = S_RD_WAIT;
                end else begin
                    nxt_s = S_IDLE;
                end
            end
            S_WR_WAIT:  if (!dav_s)     nxt_s = S_WR_HOLD;  else nxt_s = state_q;
            S_WR_HOLD:  if (rx_ready_i) nxt_s = S_WR_ACK;   else nxt_s = state_q;
            S_WR_ACK:   if (dav_s)      nxt_s = S_WR_REL;   else nxt_s = state_q;
            S_WR_REL:   nxt_s = S_IDLE;
            S_RD_WAIT:  if (!dav_s)     nxt_s = S_RD_FETCH; else nxt_s = state_q;
            S_RD_FETCH: if (tx_valid_i) nxt_s = S_RD_ACK;   else nxt_s = state_q;
            S_RD_ACK:   if (dav_s)      nxt_s = S_RD_REL;   else nxt_s = state_q;
            S_RD_REL:   nxt_s = S_IDLE;
            default:    nxt_s = S_IDLE;
        endcase
    end

    // Watchdog runs only while waiting on the host. Local stream stalls never time out.
    always_comb begin
        timed_s = (state_q != S_IDLE) && (state_q != S_WR_HOLD) && (state_q != S_RD_FETCH);
        abort_s = timed_s && (nxt_s == state_q) && (cnt_q == CNT_W'(TIMEOUT - 1));
        if (abort_s || (nxt_s != state_q)) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (timed_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Handshake FSM with all of its registered outputs.
    // ACK falls on entry to the code phase. Every other ACK edge is taken one clock
    // after the state that asks for it, so a released DAV shows up as ACK high
    // SYNC_STAGES+2 clocks later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            code_q      <= 8'h00;
            ack_q       <= 1'b1;
            bus_oe_q    <= 1'b0;
            bus_out_q   <= 8'h00;
            status_q    <= ST_OK;
            rx_data_q   <= 8'h00;
            rx_is_cmd_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_ready_q <= 1'b0;
            err_q      <= 1'b0;
            if (abort_s) begin
                state_q    <= S_IDLE;
                ack_q      <= 1'b1;
                bus_oe_q   <= 1'b0;
                rx_valid_q <= 1'b0;
                status_q   <= ST_TMO;
                err_q      <= 1'b1;
            end else begin
                state_q <= nxt_s;
                case (state_q)
                    S_IDLE: begin
                        if (!dav_s) begin
                            code_q <= bus_in_i;
                            ack_q  <= 1'b0;
                            if (valid_code(bus_in_i)) begin
                                status_q <= ST_OK;
                            end else begin
                                status_q <= ST_BAD;
                                err_q    <= 1'b1;
                            end
                        end
                    end
                    S_CODE_ACK: ack_q <= 1'b0;
                    S_CODE_REL: ack_q <= 1'b1;
                    S_WR_WAIT: begin
                        if (!dav_s) begin
                            rx_data_q   <= bus_in_i;
                            rx_is_cmd_q <= (code_q == CODE_CMD);
                            rx_valid_q  <= 1'b1;
                        end
                    end
                    S_WR_HOLD: begin
                        if (rx_ready_i) begin
                            rx_valid_q <= 1'b0;
                            status_q   <= rx_status_i;
                        end
                    end
                    S_WR_ACK:  ack_q <= 1'b0;
                    S_WR_REL:  ack_q <= 1'b1;
                    S_RD_WAIT: ack_q <= 1'b1;
                    S_RD_FETCH: begin
                        if (tx_valid_i) begin
                            bus_out_q  <= tx_data_i;
                            status_q   <= tx_status_i;
                            bus_oe_q   <= 1'b1;
                            tx_ready_q <= 1'b1;
                        end
                    end
                    S_RD_ACK: begin
                        ack_q <= 1'b0;
                        if (dav_s) begin
                            bus_oe_q <= 1'b0;
                        end
                    end
                    S_RD_REL: ack_q <= 1'b1;
                    default: begin
                        ack_q      <= 1'b1;
                        bus_oe_q   <= 1'b0;
                        rx_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ack_o       = ack_q;
    assign bus_oe_o    = bus_oe_q;
    assign bus_out_o   = bus_out_q;
    assign status_o    = status_q;
    assign rx_data_o   = rx_data_q;
    assign rx_is_cmd_o = rx_is_cmd_q;
    assign rx_valid_o  = rx_valid_q;
    assign tx_ready_o  = tx_ready_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_tcbm_drive_responder.sv
// Directed bench for tcbm_drive_responder with SYNC_STAGES=2 and TIMEOUT=16.
module tb_tcbm_drive_responder;

    localparam int SYNC = 2;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dav;
    logic       ack;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [1:0] status;
    logic [7:0] rx_data;
    logic       rx_is_cmd;
    logic       rx_valid;
    logic       rx_ready;
    logic [1:0] rx_status;
    logic [7:0] tx_data;
    logic [1:0] tx_status;
    logic       tx_valid;
    logic       tx_ready;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Event counters observed at the active edge.
    int         acc_cnt  = 0;
    int         txr_cnt  = 0;
    int         err_cnt  = 0;
    int         fall_cnt = 0;
    logic       prev_ack = 1'b1;
    logic [7:0] last_rx  = 8'h00;
    logic       last_cmd = 1'b0;

    always #5 clk = ~clk;

    tcbm_drive_responder #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dav_i(dav), .ack_o(ack),
        .bus_in_i(bus_in), .bus_out_o(bus_out), .bus_oe_o(bus_oe), .status_o(status),
        .rx_data_o(rx_data), .rx_is_cmd_o(rx_is_cmd), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .rx_status_i(rx_status),
        .tx_data_i(tx_data), .tx_status_i(tx_status), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .err_o(err)
    );

    // Count accepts, tx consumes, err pulses and ACK falling edges.
    always @(posedge clk) begin
        if (rx_valid && rx_ready) begin
            acc_cnt  <= acc_cnt + 1;
            last_rx  <= rx_data;
            last_cmd <= rx_is_cmd;
        end
        if (tx_ready) txr_cnt <= txr_cnt + 1;
        if (err)      err_cnt <= err_cnt + 1;
        if (prev_ack && !ack) fall_cnt <= fall_cnt + 1;
        prev_ack <= ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string nm, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ack !== lvl && cyc < 200);
        checks++;
        if (ack !== lvl) begin
            errors++;
            $display("FAIL %s: ack=%b after %0d clocks, required %b", nm, ack, cyc, lvl);
        end
    endtask

    task automatic host_xfer(input logic [7:0] b, output int fc, output int rc);
        bus_in = b;
        dav    = 1'b0;
        wait_ack(1'b0, "ack_fall", fc);
        dav    = 1'b1;
        wait_ack(1'b1, "ack_rise", rc);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL rst_ack: %b vs 1", ack); end
        checks++; if (bus_oe !== 1'b0)    begin errors++; $display("FAIL rst_bus_oe: %b vs 0", bus_oe); end
        checks++; if (bus_out !== 8'h00)  begin errors++; $display("FAIL rst_bus_out: %h vs 00", bus_out); end
        checks++; if (status !== 2'b00)   begin errors++; $display("FAIL rst_status: %b vs 00", status); end
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL rst_rx_valid: %b vs 0", rx_valid); end
        checks++; if (rx_is_cmd !== 1'b0) begin errors++; $display("FAIL rst_rx_is_cmd: %b vs 0", rx_is_cmd); end
        checks++; if (tx_ready !== 1'b0)  begin errors++; $display("FAIL rst_tx_ready: %b vs 0", tx_ready); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: %b vs 0", err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_cmd();
        int fc, rc, a0, f0;
        a0 = acc_cnt; f0 = fall_cnt;
        rx_ready = 1'b1; rx_status = 2'b00;
        host_xfer(8'h81, fc, rc);
        checks++; if (fc != SYNC + 1) begin errors++; $display("FAIL t1_code_fall_lat: %0d vs %0d", fc, SYNC + 1); end
        checks++; if (rc != SYNC + 2) begin errors++; $display("FAIL t1_code_rise_lat: %0d vs %0d", rc, SYNC + 2); end
        host_xfer(8'h49, fc, rc);
        checks++; if (fc != SYNC + 3) begin errors++; $display("FAIL t1_byte_fall_lat: %0d vs %0d", fc, SYNC + 3); end
        checks++; if (rc != SYNC + 2) begin errors++; $display("FAIL t1_byte_rise_lat: %0d vs %0d", rc, SYNC + 2); end
        checks++; if (acc_cnt - a0 != 1) begin errors++; $display("FAIL t1_accepts: %0d vs 1", acc_cnt - a0); end
        checks++; if (last_rx !== 8'h49) begin errors++; $display("FAIL t1_rx_data: %h vs 49", last_rx); end
        checks++; if (last_cmd !== 1'b1) begin errors++; $display("FAIL t1_rx_is_cmd: %b vs 1", last_cmd); end
        checks++; if (fall_cnt - f0 != 2) begin errors++; $display("FAIL t1_ack_cycles: %0d vs 2", fall_cnt - f0); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL t1_status: %b vs 00", status); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t1_rx_valid: %b vs 0", rx_valid); end
        rx_ready = 1'b0;
    endtask

    task automatic test_read_eoi();
        int fc, rc, t0;
        logic p_oe, p_ack;
        logic [7:0] p_out;
        t0 = txr_cnt;
        tx_valid = 1'b1; tx_data = 8'hA5; tx_status = 2'b11;
        host_xfer(8'h83, fc, rc);
        bus_in = 8'h00;
        dav = 1'b0;
        fc = 0; p_oe = 1'b0; p_ack = 1'b1; p_out = 8'h00;
        while (ack === 1'b1 && fc < 50) begin
            p_oe = bus_oe; p_out = bus_out; p_ack = ack;
            tick();
            fc++;
        end
        checks++; if (fc != SYNC + 3) begin errors++; $display("FAIL t2_rd_fall_lat: %0d vs %0d", fc, SYNC + 3); end
        checks++; if (p_oe !== 1'b1 || p_ack !== 1'b1) begin errors++; $display("FAIL t2_oe_setup: oe=%b ack=%b vs 1 1", p_oe, p_ack); end
        checks++; if (p_out !== 8'hA5) begin errors++; $display("FAIL t2_setup_data: %h vs a5", p_out); end
        checks++; if (bus_out !== 8'hA5 || bus_oe !== 1'b1) begin errors++; $display("FAIL t2_drive: %h/%b vs a5/1", bus_out, bus_oe); end
        checks++; if (status !== 2'b11) begin errors++; $display("FAIL t2_status: %b vs 11", status); end
        checks++; if (txr_cnt - t0 != 1) begin errors++; $display("FAIL t2_tx_ready: %0d vs 1", txr_cnt - t0); end
        tx_valid = 1'b0;
        dav = 1'b1;
        wait_ack(1'b1, "t2_ack_rise", rc);
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL t2_oe_release: %b vs 0", bus_oe); end
    endtask

    task automatic test_backpressure();
        int fc, rc, a0, n, bad;
        a0 = acc_cnt;
        rx_ready = 1'b0; rx_status = 2'b00;
        host_xfer(8'h82, fc, rc);
        bus_in = 8'h10;
        dav = 1'b0;
        n = 0;
        while (rx_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL t3_rx_valid_rise: %b vs 1", rx_valid); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack !== 1'b1 || rx_valid !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL t3_hold: %0d bad clocks vs 0", bad); end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0 || ack !== 1'b1) begin errors++; $display("FAIL t3_accept: rx_valid=%b ack=%b vs 0 1", rx_valid, ack); end
        tick();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t3_ack_fall: %b vs 0", ack); end
        checks++; if (acc_cnt - a0 != 1) begin errors++; $display("FAIL t3_accepts: %0d vs 1", acc_cnt - a0); end
        checks++; if (last_rx !== 8'h10 || last_cmd !== 1'b0) begin errors++; $display("FAIL t3_rx: %h/%b vs 10/0", last_rx, last_cmd); end
        dav = 1'b1;
        wait_ack(1'b1, "t3_ack_rise", rc);
    endtask

    task automatic test_bad_code();
        int fc, rc, e0, a0, f0;
        e0 = err_cnt; a0 = acc_cnt; f0 = fall_cnt;
        host_xfer(8'h55, fc, rc);
        for (int i = 0; i < 6; i++) tick();
        checks++; if (status !== 2'b10) begin errors++; $display("FAIL t4_status: %b vs 10", status); end
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL t4_err_pulses: %0d vs 1", err_cnt - e0); end
        checks++; if (acc_cnt - a0 != 0 || rx_valid !== 1'b0) begin errors++; $display("FAIL t4_no_rx: %0d/%b vs 0/0", acc_cnt - a0, rx_valid); end
        checks++; if (fall_cnt - f0 != 1 || ack !== 1'b1) begin errors++; $display("FAIL t4_ack_cycles: %0d/%b vs 1/1", fall_cnt - f0, ack); end
    endtask

    task automatic test_timeout();
        int fc, rc, e0, early;
        e0 = err_cnt;
        host_xfer(8'h82, fc, rc);
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL t5_code_status: %b vs 00", status); end
        early = 0;
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (err !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL t5_early_err: %0d vs 0", early); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t5_err: %b vs 1", err); end
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL t5_status: %b vs 01", status); end
        checks++; if (ack !== 1'b1 || bus_oe !== 1'b0) begin errors++; $display("FAIL t5_lines: ack=%b oe=%b vs 1 0", ack, bus_oe); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (status !== 2'b01 || err_cnt - e0 != 1) begin errors++; $display("FAIL t5_hold: %b/%0d vs 01/1", status, err_cnt - e0); end
    endtask

    task automatic test_reset_mid_read();
        int fc, rc, t0;
        tx_valid = 1'b1; tx_data = 8'h5A; tx_status = 2'b00;
        host_xfer(8'h83, fc, rc);
        bus_in = 8'h00;
        dav = 1'b0;
        wait_ack(1'b0, "t6_rd_ack", fc);
        checks++; if (bus_oe !== 1'b1) begin errors++; $display("FAIL t6_oe_before: %b vs 1", bus_oe); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ack !== 1'b1 || bus_oe !== 1'b0) begin errors++; $display("FAIL t6_async: ack=%b oe=%b vs 1 0", ack, bus_oe); end
        dav = 1'b1; tx_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        t0 = txr_cnt;
        tx_valid = 1'b1; tx_data = 8'h3C; tx_status = 2'b00;
        host_xfer(8'h83, fc, rc);
        checks++; if (fc != SYNC + 1) begin errors++; $display("FAIL t6_code_lat: %0d vs %0d", fc, SYNC + 1); end
        dav = 1'b0;
        wait_ack(1'b0, "t6_rd2_ack", fc);
        checks++; if (bus_out !== 8'h3C || bus_oe !== 1'b1) begin errors++; $display("FAIL t6_read: %h/%b vs 3c/1", bus_out, bus_oe); end
        checks++; if (txr_cnt - t0 != 1) begin errors++; $display("FAIL t6_tx_ready: %0d vs 1", txr_cnt - t0); end
        tx_valid = 1'b0;
        dav = 1'b1;
        wait_ack(1'b1, "t6_rd2_rel", rc);
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL t6_oe_release: %b vs 0", bus_oe); end
    endtask

    initial begin
        rst_n = 1'b0; dav = 1'b1; bus_in = 8'h00;
        rx_ready = 1'b0; rx_status = 2'b00;
        tx_data = 8'h00; tx_status = 2'b00; tx_valid = 1'b0;
        test_reset();
        test_write_cmd();
        test_read_eoi();
        test_backpressure();
        test_bad_code();
        test_timeout();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
